unidade_controle_mc: RTL and testbench

UNIDADE_CONTROLE_MC -- requirements
Module: unidade_controle_mc

---
 rtl/unidade_controle_mc.sv | 193 +++++++++++++++++++
 tb/tb_unidade_controle_mc.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_mc.sv
// Multicycle control unit for a small RV64-subset datapath: add/sub/and, addi, ld, sd, beq/bne, ecall-style halt.
// Latency: R/I 5 cycles, load 7, store 6, branch taken 4 / not taken 5, measured FETCH to next FETCH.
// Backpressure: none; memories are assumed fixed-latency, so the sequence never stalls.
module unidade_controle_mc #(
    parameter int HALT_ON_ILLEGAL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    output logic       PCwrite,
    output logic       IRwrite,
    output logic       RegWrite,
    output logic       loadRegA,
    output logic       loadRegB,
    output logic       loadRegAluOut,
    output logic       loadRegMemData,
    output logic       DataMemWr,
    output logic       SelMuxA,
    output logic       SelMuxPC,
    output logic       SelMuxMem,
    output logic [1:0] SelMuxB,
    output logic [2:0] AluOperation,
    output logic [3:0] state_out,
    output logic       halted,
    output logic       illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] ALU_IDLE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;

    typedef enum logic [3:0] {
        RESET_ST  = 4'd0,
        FETCH     = 4'd1,
        FETCH_IR  = 4'd2,
        DECODE    = 4'd3,
        EXEC_R    = 4'd4,
        EXEC_I    = 4'd5,
        MEM_ADDR  = 4'd6,
        LOAD_WAIT = 4'd7,
        LOAD_MDR  = 4'd8,
        WB_ALU    = 4'd9,
        WB_LOAD   = 4'd10,
        STORE     = 4'd11,
        BRANCH    = 4'd12,
        PC_INC    = 4'd13,
        HALT      = 4'd14
    } state_t;

    state_t state;
    state_t next_state;
    logic   take_illegal;
    logic   illegal_q;

    assign state_out = state;
    assign illegal   = illegal_q;

    // State register and sticky illegal flag; reset wins from any state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RESET_ST;
            illegal_q <= 1'b0;
        end else begin
            state <= next_state;
            if (take_illegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Next-state and control decode; everything defaults low and each state raises only what it needs.
    always_comb begin
        next_state     = RESET_ST;
        take_illegal   = 1'b0;
        PCwrite        = 1'b0;
        IRwrite        = 1'b0;
        RegWrite       = 1'b0;
        loadRegA       = 1'b0;
        loadRegB       = 1'b0;
        loadRegAluOut  = 1'b0;
        loadRegMemData = 1'b0;
        DataMemWr      = 1'b0;
        SelMuxA        = 1'b0;
        SelMuxPC       = 1'b0;
        SelMuxMem      = 1'b0;
        SelMuxB        = 2'd0;
        AluOperation   = ALU_IDLE;
        halted         = 1'b0;

        case (state)
            RESET_ST: next_state = FETCH;
            // Instruction memory read is in flight; nothing to latch yet.
            FETCH:    next_state = FETCH_IR;
            FETCH_IR: begin
                IRwrite    = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                // Read registers and precompute the branch target from the un-incremented PC.
                loadRegA      = 1'b1;
                loadRegB      = 1'b1;
                SelMuxA       = 1'b0;
                SelMuxB       = 2'd3;
                AluOperation  = ALU_ADD;
                loadRegAluOut = 1'b1;
                case (opcode)
                    OP_R:      next_state = EXEC_R;
                    OP_I:      if (funct3 == 3'b000) next_state = EXEC_I;   else take_illegal = 1'b1;
                    OP_LOAD:   if (funct3 == 3'b011) next_state = MEM_ADDR; else take_illegal = 1'b1;
                    OP_STORE:  if (funct3 == 3'b011) next_state = MEM_ADDR; else take_illegal = 1'b1;
                    OP_BRANCH: if (funct3 == 3'b000 || funct3 == 3'b001) next_state = BRANCH;
                               else take_illegal = 1'b1;
                    OP_SYSTEM: next_state = HALT;
                    default:   take_illegal = 1'b1;
                endcase
            end
            EXEC_R: begin
                SelMuxA       = 1'b1;
                SelMuxB       = 2'd0;
                loadRegAluOut = 1'b1;
                next_state    = WB_ALU;
                if (funct3 == 3'b000 && funct7 == 7'b0000000)      AluOperation = ALU_ADD;
                else if (funct3 == 3'b000 && funct7 == 7'b0100000) AluOperation = ALU_SUB;
                else if (funct3 == 3'b111 && funct7 == 7'b0000000) AluOperation = ALU_AND;
                else take_illegal = 1'b1;
            end
            EXEC_I, MEM_ADDR: begin
                SelMuxA       = 1'b1;
                SelMuxB       = 2'd2;
                AluOperation  = ALU_ADD;
                loadRegAluOut = 1'b1;
                if (state == EXEC_I)        next_state = WB_ALU;
                else if (opcode == OP_LOAD) next_state = LOAD_WAIT;
                else                        next_state = STORE;
            end
            // Data memory read is in flight.
            LOAD_WAIT: next_state = LOAD_MDR;
            LOAD_MDR: begin
                loadRegMemData = 1'b1;
                next_state     = WB_LOAD;
            end
            WB_ALU, WB_LOAD, PC_INC: begin
                // Writeback (if any) shares the cycle with PC <= PC + 4.
                RegWrite     = (state != PC_INC);
                SelMuxMem    = (state == WB_LOAD);
                SelMuxA      = 1'b0;
                SelMuxB      = 2'd1;
                AluOperation = ALU_ADD;
                SelMuxPC     = 1'b0;
                PCwrite      = 1'b1;
                next_state   = FETCH;
            end
            STORE: begin
                DataMemWr  = 1'b1;
                next_state = PC_INC;
            end
            BRANCH: begin
                SelMuxA      = 1'b1;
                SelMuxB      = 2'd0;
                AluOperation = ALU_SUB;
                if ((funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero)) begin
                    PCwrite    = 1'b1;
                    SelMuxPC   = 1'b1;
                    next_state = FETCH;
                end else begin
                    next_state = PC_INC;
                end
            end
            HALT: begin
                halted     = 1'b1;
                next_state = HALT;
            end
            default: next_state = RESET_ST;
        endcase

        // An illegal instruction either stops the core or is skipped with a plain PC increment.
        if (take_illegal) begin
            next_state = (HALT_ON_ILLEGAL != 0) ? HALT : PC_INC;
        end
    end

endmodule

// File: tb/tb_unidade_controle_mc.sv
module tb_unidade_controle_mc;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;

    logic PCwrite, IRwrite, RegWrite, loadRegA, loadRegB, loadRegAluOut, loadRegMemData, DataMemWr;
    logic SelMuxA, SelMuxPC, SelMuxMem, halted, illegal;
    logic [1:0] SelMuxB;
    logic [2:0] AluOperation;
    logic [3:0] state_out;

    logic s_PCwrite, s_IRwrite, s_RegWrite, s_loadRegA, s_loadRegB, s_loadRegAluOut, s_loadRegMemData;
    logic s_DataMemWr, s_SelMuxA, s_SelMuxPC, s_SelMuxMem, s_halted, s_illegal;
    logic [1:0] s_SelMuxB;
    logic [2:0] s_AluOperation;
    logic [3:0] s_state_out;

    int tests = 0;
    int fails = 0;

    unidade_controle_mc dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7), .zero(zero),
        .PCwrite(PCwrite), .IRwrite(IRwrite), .RegWrite(RegWrite), .loadRegA(loadRegA),
        .loadRegB(loadRegB), .loadRegAluOut(loadRegAluOut), .loadRegMemData(loadRegMemData),
        .DataMemWr(DataMemWr), .SelMuxA(SelMuxA), .SelMuxPC(SelMuxPC), .SelMuxMem(SelMuxMem),
        .SelMuxB(SelMuxB), .AluOperation(AluOperation), .state_out(state_out),
        .halted(halted), .illegal(illegal)
    );

    unidade_controle_mc #(.HALT_ON_ILLEGAL(0)) dut_skip (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7), .zero(zero),
        .PCwrite(s_PCwrite), .IRwrite(s_IRwrite), .RegWrite(s_RegWrite), .loadRegA(s_loadRegA),
        .loadRegB(s_loadRegB), .loadRegAluOut(s_loadRegAluOut), .loadRegMemData(s_loadRegMemData),
        .DataMemWr(s_DataMemWr), .SelMuxA(s_SelMuxA), .SelMuxPC(s_SelMuxPC), .SelMuxMem(s_SelMuxMem),
        .SelMuxB(s_SelMuxB), .AluOperation(s_AluOperation), .state_out(s_state_out),
        .halted(s_halted), .illegal(s_illegal)
    );

    // {PCwrite,IRwrite,RegWrite,ldA,ldB,ldAluOut,ldMDR,MemWr,SelA,SelPC,SelMem,SelB[1:0],AluOp[2:0],halted}
    logic [16:0] out_word;
    assign out_word = {PCwrite, IRwrite, RegWrite, loadRegA, loadRegB, loadRegAluOut, loadRegMemData,
                       DataMemWr, SelMuxA, SelMuxPC, SelMuxMem, SelMuxB, AluOperation, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        z;
        int          len;
        logic [31:0] seq;   // expected state codes, first in the top nibble
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(string n, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                logic z, int len, logic [31:0] seq);
        vec_t v;
        v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.len = len; v.seq = seq;
        return v;
    endfunction

    // Expected control word per state, written from the control table.
    function automatic logic [16:0] exp_out(logic [3:0] st, logic [6:0] op, logic [2:0] f3,
                                            logic [6:0] f7, logic z);
        logic pcw, irw, rw, la, lb, lo, lm, mw, sa, spc, sm, h;
        logic [1:0] sb;
        logic [2:0] alu;
        {pcw, irw, rw, la, lb, lo, lm, mw, sa, spc, sm, h} = '0;
        sb = 2'd0; alu = 3'b000;
        case (st)
            4'd2: irw = 1'b1;
            4'd3: begin la = 1; lb = 1; sb = 2'd3; alu = 3'b001; lo = 1; end
            4'd4: begin
                sa = 1; lo = 1;
                if (f3 == 3'b000 && f7 == 7'h00)      alu = 3'b001;
                else if (f3 == 3'b000 && f7 == 7'h20) alu = 3'b010;
                else if (f3 == 3'b111 && f7 == 7'h00) alu = 3'b011;
            end
            4'd5, 4'd6: begin sa = 1; sb = 2'd2; alu = 3'b001; lo = 1; end
            4'd8: lm = 1'b1;
            4'd9:  begin rw = 1; pcw = 1; sb = 2'd1; alu = 3'b001; end
            4'd10: begin rw = 1; sm = 1; pcw = 1; sb = 2'd1; alu = 3'b001; end
            4'd11: mw = 1'b1;
            4'd12: begin
                sa = 1; alu = 3'b010;
                if ((f3 == 3'b000 && z) || (f3 == 3'b001 && !z)) begin pcw = 1; spc = 1; end
            end
            4'd13: begin pcw = 1; sb = 2'd1; alu = 3'b001; end
            4'd14: h = 1'b1;
            default: ;
        endcase
        return {pcw, irw, rw, la, lb, lo, lm, mw, sa, spc, sm, sb, alu, h};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next falling edge so outputs are settled and far from posedge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic z);
        opcode = op; funct3 = f3; funct7 = f7; zero = z;
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget);
        int n;
        n = 0;
        while (state_out != s && n < budget) begin
            step();
            n++;
        end
        chk($sformatf("wait_state_%0d", s), 32'(state_out), 32'(s));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        chk("reset_state", 32'(state_out), 32'd0);
        chk("reset_illegal", 32'({illegal, s_illegal}), 32'd0);
        rst = 1'b1;
        step();
        chk("reset_release_fetch", 32'(state_out), 32'd1);
    endtask

    initial begin
        logic [3:0] es;

        vecs[0] = mk("add",     7'b0110011, 3'b000, 7'h00, 1'b0, 5, 32'h1234_9000);
        vecs[1] = mk("sub",     7'b0110011, 3'b000, 7'h20, 1'b0, 5, 32'h1234_9000);
        vecs[2] = mk("and",     7'b0110011, 3'b111, 7'h00, 1'b1, 5, 32'h1234_9000);
        vecs[3] = mk("addi",    7'b0010011, 3'b000, 7'h55, 1'b0, 5, 32'h1235_9000);
        vecs[4] = mk("ld",      7'b0000011, 3'b011, 7'h00, 1'b0, 7, 32'h1236_78A0);
        vecs[5] = mk("sd",      7'b0100011, 3'b011, 7'h00, 1'b0, 6, 32'h1236_BD00);
        vecs[6] = mk("beq_tk",  7'b1100011, 3'b000, 7'h00, 1'b1, 4, 32'h123C_0000);
        vecs[7] = mk("beq_nt",  7'b1100011, 3'b000, 7'h00, 1'b0, 5, 32'h123C_D000);
        vecs[8] = mk("bne_tk",  7'b1100011, 3'b001, 7'h00, 1'b0, 4, 32'h123C_0000);
        vecs[9] = mk("bne_nt",  7'b1100011, 3'b001, 7'h00, 1'b1, 5, 32'h123C_D000);

        set_in(7'b0110011, 3'b000, 7'h00, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_reset_state", 32'(state_out), 32'd0);
            chk("hold_reset_outs", 32'({out_word, illegal}), 32'd0);
        end
        rst = 1'b1;
        step();
        chk("first_fetch", 32'(state_out), 32'd1);

        // Table: one instruction per row, FETCH to the following FETCH.
        for (int v = 0; v < 10; v++) begin
            set_in(vecs[v].op, vecs[v].f3, vecs[v].f7, vecs[v].z);
            #1;
            for (int k = 0; k < vecs[v].len; k++) begin
                es = vecs[v].seq[31 - 4*k -: 4];
                chk($sformatf("%s_state_c%0d", vecs[v].name, k), 32'(state_out), 32'(es));
                chk($sformatf("%s_outs_c%0d", vecs[v].name, k), 32'(out_word),
                    32'(exp_out(es, vecs[v].op, vecs[v].f3, vecs[v].f7, vecs[v].z)));
                step();
            end
            chk($sformatf("%s_next_fetch", vecs[v].name), 32'(state_out), 32'd1);
            chk($sformatf("%s_no_illegal", vecs[v].name), 32'(illegal), 32'd0);
        end

        // Unsupported opcode: default instance halts, skip instance increments PC and continues.
        set_in(7'b1111111, 3'b000, 7'h00, 1'b0);
        step(); step();
        chk("ill_decode", 32'(state_out), 32'd3);
        chk("ill_not_yet_flagged", 32'(illegal), 32'd0);
        step();
        chk("ill_halt_state", 32'(state_out), 32'd14);
        chk("ill_skip_pcinc", 32'(s_state_out), 32'd13);
        chk("ill_skip_flag", 32'(s_illegal), 32'd1);
        chk("ill_skip_pcwrite", 32'(s_PCwrite), 32'd1);
        step();
        chk("ill_skip_fetch", 32'(s_state_out), 32'd1);
        set_in(7'b0110011, 3'b000, 7'h00, 1'b0);
        #1;
        for (int k = 0; k < 20; k++) begin
            chk("halt_hold", 32'({state_out, halted, illegal, out_word}),
                32'({4'd14, 1'b1, 1'b1, 17'h00001}));
            if (k < 5) begin
                es = vecs[0].seq[31 - 4*k -: 4];
                chk("skip_continues", 32'(s_state_out), 32'(es));
            end else if (k == 5) begin
                chk("skip_refetch_sticky", 32'({s_state_out, s_illegal}), 32'({4'd1, 1'b1}));
            end
            step();
        end
        do_reset();

        // Illegal R-type function combination detected in EXEC_R.
        set_in(7'b0110011, 3'b000, 7'h01, 1'b0);
        wait_state(4'd4, 6);
        chk("badr_aluop", 32'(AluOperation), 32'd0);
        step();
        chk("badr_halt", 32'({state_out, illegal}), 32'({4'd14, 1'b1}));
        chk("badr_skip_pcinc", 32'({s_state_out, s_illegal}), 32'({4'd13, 1'b1}));
        do_reset();

        // System opcode halts without flagging illegal.
        set_in(7'b1110011, 3'b000, 7'h00, 1'b0);
        wait_state(4'd14, 6);
        chk("ecall_flags", 32'({halted, illegal}), 32'({1'b1, 1'b0}));
        do_reset();

        // Reset landing in the middle of a store aborts it.
        set_in(7'b0100011, 3'b011, 7'h00, 1'b0);
        wait_state(4'd11, 8);
        chk("store_memwr", 32'(DataMemWr), 32'd1);
        rst = 1'b0;
        step();
        chk("store_abort_state", 32'(state_out), 32'd0);
        chk("store_abort_outs", 32'({out_word, DataMemWr}), 32'd0);
        step();
        chk("store_abort_hold", 32'({state_out, DataMemWr}), 32'd0);
        rst = 1'b1;
        step();
        chk("store_abort_fetch", 32'(state_out), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
